// File: rtl/instruction_buffer_pkg.sv
// Shared core types for the fetch/decode instruction queue.
package instruction_buffer_pkg;

  localparam int IBUF_DEPTH = 8;
  localparam int IBUF_XLEN  = 32;

  typedef struct packed {
    logic [IBUF_XLEN-1:0] instr;
    logic [IBUF_XLEN-1:0] addr;
  } ibuf_entry_t;

endpackage

// File: rtl/instruction_buffer.sv
// Dual-issue instruction queue: up to two enqueues and two dequeues per cycle,
// two oldest entries presented combinationally to decode.
module instruction_buffer
  import instruction_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int XLEN  = IBUF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] instructionA,
  input  logic [XLEN-1:0] addressA,
  input  logic            instructionA_valid,
  input  logic [XLEN-1:0] instructionB,
  input  logic [XLEN-1:0] addressB,
  input  logic            instructionB_valid,
  output logic            stall,
  output logic [XLEN-1:0] head0_instr,
  output logic [XLEN-1:0] head0_addr,
  output logic            head0_valid,
  output logic [XLEN-1:0] head1_instr,
  output logic [XLEN-1:0] head1_addr,
  output logic            head1_valid,
  input  logic [1:0]      deq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] STALL_LVL = (PW+1)'(DEPTH - 2);

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] addr_mem  [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW:0]   count_reg, count_next;

  logic [PW-1:0] rd1_ptr, wr1_ptr;
  logic [PW:0]   enq_n, deq_req, deq_n;
  logic          wr0_en, wr1_en;
  logic [XLEN-1:0] slot0_instr, slot0_addr;

  // Stall depends only on registered count so fetch sees no input-to-output path.
  assign stall = (count_reg > STALL_LVL);

  assign rd1_ptr = rd_ptr_reg + PW'(1);
  assign wr1_ptr = wr_ptr_reg + PW'(1);

  // Compact the valid slots: A first, B fills whichever slot is next.
  assign slot0_instr = instructionA_valid ? instructionA : instructionB;
  assign slot0_addr  = instructionA_valid ? addressA     : addressB;

  always_comb begin
    enq_n = '0;
    if (!stall && !flush)
      enq_n = (PW+1)'(instructionA_valid) + (PW+1)'(instructionB_valid);
  end

  assign wr0_en = (enq_n != '0);
  assign wr1_en = (enq_n == (PW+1)'(2));

  always_comb begin
    deq_req = (deq_count == 2'd0) ? (PW+1)'(0) :
              (deq_count == 2'd1) ? (PW+1)'(1) : (PW+1)'(2);
    deq_n   = (deq_req > count_reg) ? count_reg : deq_req;
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg + deq_n[PW-1:0];
    wr_ptr_next = wr_ptr_reg + enq_n[PW-1:0];
    count_next  = count_reg - deq_n + enq_n;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is left unreset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      instr_mem[wr_ptr_reg] <= slot0_instr;
      addr_mem[wr_ptr_reg]  <= slot0_addr;
    end
    if (wr1_en) begin
      instr_mem[wr1_ptr] <= instructionB;
      addr_mem[wr1_ptr]  <= addressB;
    end
  end

  assign head0_valid = (count_reg >= (PW+1)'(1));
  assign head1_valid = (count_reg >= (PW+1)'(2));
  assign head0_instr = head0_valid ? instr_mem[rd_ptr_reg] : '0;
  assign head0_addr  = head0_valid ? addr_mem[rd_ptr_reg]  : '0;
  assign head1_instr = head1_valid ? instr_mem[rd1_ptr]    : '0;
  assign head1_addr  = head1_valid ? addr_mem[rd1_ptr]     : '0;

  always_ff @(posedge clk) begin
    if (!reset) assert (count_reg <= DEPTH_C);
  end

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer: fill, stall, wrap, concurrent
// enqueue/dequeue, flush, clamped dequeue and reset priority.
module tb_instruction_buffer;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] instructionA, addressA, instructionB, addressB;
  logic        instructionA_valid, instructionB_valid;
  logic        stall, head0_valid, head1_valid;
  logic [31:0] head0_instr, head0_addr, head1_instr, head1_addr;
  logic [1:0]  deq_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instruction_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instructionA(instructionA), .addressA(addressA), .instructionA_valid(instructionA_valid),
    .instructionB(instructionB), .addressB(addressB), .instructionB_valid(instructionB_valid),
    .stall(stall),
    .head0_instr(head0_instr), .head0_addr(head0_addr), .head0_valid(head0_valid),
    .head1_instr(head1_instr), .head1_addr(head1_addr), .head1_valid(head1_valid),
    .deq_count(deq_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; deq_count = 2'd0;
    instructionA_valid = 1'b0; instructionB_valid = 1'b0;
    instructionA = '0; addressA = '0; instructionB = '0; addressB = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic offer(input logic av, input logic [31:0] ai, input logic [31:0] aa,
                       input logic bv, input logic [31:0] bi, input logic [31:0] ba);
    instructionA_valid = av; instructionA = ai; addressA = aa;
    instructionB_valid = bv; instructionB = bi; addressB = ba;
  endtask

  task automatic heads(input string tag, input logic v0, input logic [31:0] i0, input logic [31:0] a0,
                       input logic v1, input logic [31:0] i1, input logic [31:0] a1);
    check({tag, ".h0v"}, 32'(head0_valid), 32'(v0));
    check({tag, ".h0i"}, head0_instr, i0);
    check({tag, ".h0a"}, head0_addr, a0);
    check({tag, ".h1v"}, 32'(head1_valid), 32'(v1));
    check({tag, ".h1i"}, head1_instr, i1);
    check({tag, ".h1a"}, head1_addr, a1);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    check("rst.stall", 32'(stall), 0);
    heads("rst", 0, 0, 0, 0, 0, 0);

    // Pair into empty queue
    offer(1, 32'h0000_0013, 32'h0, 1, 32'h0010_0093, 32'h4);
    step();
    check("t1.stall", 32'(stall), 0);
    heads("t1", 1, 32'h13, 32'h0, 1, 32'h0010_0093, 32'h4);

    // Fill to 7
    offer(1, 32'h100, 32'h08, 1, 32'h104, 32'h0c); step();
    offer(1, 32'h108, 32'h10, 1, 32'h10c, 32'h14); step();
    check("t2.stall6", 32'(stall), 0);
    offer(1, 32'h110, 32'h18, 0, 0, 0); step();
    check("t2.stall7", 32'(stall), 1);
    offer(1, 32'hdead_0000, 32'hf0, 1, 32'hdead_0001, 32'hf4); step();
    check("t2.hold", 32'(stall), 1);
    heads("t2", 1, 32'h13, 32'h0, 1, 32'h0010_0093, 32'h4);

    // Dequeue two from 7 -> 5
    deq_count = 2'd2; step();
    check("t3.stall", 32'(stall), 0);
    heads("t3", 1, 32'h100, 32'h08, 1, 32'h104, 32'h0c);
    // Refill to 7 with wr_ptr wrapping past entry 7
    offer(1, 32'h200, 32'h1c, 1, 32'h204, 32'h20); step();
    check("t3.stall7", 32'(stall), 1);
    deq_count = 2'd2; step();
    heads("t3.d1", 1, 32'h108, 32'h10, 1, 32'h10c, 32'h14);
    deq_count = 2'd2; step();
    heads("t3.d2", 1, 32'h110, 32'h18, 1, 32'h200, 32'h1c);

    // count=3: enqueue 2 and dequeue 2 together -> 3, rd_ptr wraps
    offer(1, 32'h300, 32'h40, 1, 32'h304, 32'h44);
    deq_count = 2'd2; step();
    check("t4.stall", 32'(stall), 0);
    heads("t4", 1, 32'h204, 32'h20, 1, 32'h300, 32'h40);

    // count=5 then flush with inputs and deq offered
    offer(1, 32'h308, 32'h48, 1, 32'h30c, 32'h4c); step();
    offer(1, 32'hbad0, 32'h80, 1, 32'hbad1, 32'h84);
    flush = 1'b1; deq_count = 2'd2; step();
    check("t5.stall", 32'(stall), 0);
    heads("t5", 0, 0, 0, 0, 0, 0);
    offer(1, 32'h400, 32'h50, 1, 32'h404, 32'h54); step();
    heads("t5.post", 1, 32'h400, 32'h50, 1, 32'h404, 32'h54);

    // Over-request clamps at empty
    deq_count = 2'd1; step();
    heads("t6.c1", 1, 32'h404, 32'h54, 0, 0, 0);
    deq_count = 2'd2; step();
    heads("t6.c0", 0, 0, 0, 0, 0, 0);
    deq_count = 2'd3; step();
    check("t6.nounder", 32'(stall), 0);
    check("t6.empty", 32'(head0_valid), 0);
    offer(0, 0, 0, 1, 32'h0b0b, 32'h24); step();
    heads("t6.bonly", 1, 32'h0b0b, 32'h24, 0, 0, 0);

    // deq_count=3 behaves as 2
    offer(1, 32'h500, 32'h28, 1, 32'h504, 32'h2c); step();
    deq_count = 2'd3; step();
    heads("t7.deq3", 1, 32'h504, 32'h2c, 0, 0, 0);

    // Reset beats flush and incoming data
    offer(1, 32'h600, 32'h30, 1, 32'h604, 32'h34);
    reset = 1'b1; flush = 1'b1; step();
    heads("t8.rst", 0, 0, 0, 0, 0, 0);
    offer(1, 32'h700, 32'h38, 0, 0, 0); step();
    heads("t8.post", 1, 32'h700, 32'h38, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
